wb_dp_ram: RTL and testbench
============================

WB_DP_RAM -- requirements
Module: wb_dp_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 22, byte-address bits decoded inside the RAM; depth 2**(ADDR_WIDTH-2) 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, selected when addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH].
REQ-003 SHALL have parameter I_WAIT, default 0, range 0..15, extra wait cycles on the instruction port.
REQ-004 SHALL have parameter D_WAIT, default 0, range 0..15, extra wait cycles on the data port.
REQ-005 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset (one clock; reset asynchronous, active-low).
REQ-006 SHALL have instruction ports: iwbs_addr_i in 32 byte address; iwbs_cyc_i in 1 cycle; iwbs_stb_i in 1 strobe; iwbs_dat_o out 32 read data; iwbs_ack_o out 1 ack; iwbs_err_o out 1 error.
REQ-007 SHALL have data ports: dwbs_addr_i in 32; dwbs_dat_i in 32 write data; dwbs_sel_i in 4 byte enables; dwbs_cyc_i in 1; dwbs_stb_i in 1; dwbs_we_i in 1 write; dwbs_dat_o out 32; dwbs_ack_o out 1; dwbs_err_o out 1.

Function
REQ-008 Each port SHALL run an independent FSM: IDLE, WAIT, RESP.
REQ-009 IDLE: on cyc&stb, latch addr (word-aligned, bits [1:0] ignored), we, sel, dat; go WAIT with counter = N (N = I_WAIT/D_WAIT), or straight to RESP if N = 0.
REQ-010 WAIT: decrement the counter each cycle; go RESP on the cycle the counter reaches 0.
REQ-011 RESP: assert exactly one of ack/err for exactly one cycle, then go IDLE.
REQ-012 Ack/err SHALL rise N+1 cycles after the accepting edge; throughput is one access per N+2 cycles per port.
REQ-013 Out-of-window address SHALL produce err instead of ack with identical timing; no memory write; dat_o = 0.
REQ-014 Reads: dat_o SHALL be registered on the edge entering RESP and hold its value until the next response.
REQ-015 Writes SHALL commit only on the edge entering RESP, and only the bytes whose sel bit is set; dwbs_dat_o = 0 on a write response.
REQ-016 cyc deasserted in WAIT SHALL abort: return to IDLE, no write, no ack/err.
REQ-017 stb still high in the cycle after RESP SHALL start a new access (IDLE accepts it).
REQ-018 Same-word, same-edge instruction read and data write SHALL return pre-write data to the instruction port.
REQ-019 Byte order SHALL be little-endian: byte 0 = dat[7:0].
REQ-020 Input changes after acceptance SHALL have no effect on the in-flight access.

Reset
REQ-021 rst_i low SHALL asynchronously force both FSMs to IDLE, counters to 0, and ack/err/dat_o to 0.
REQ-022 Reset SHALL NOT clear memory contents; a write in flight when reset asserts SHALL be dropped.
REQ-023 Requests SHALL be accepted from the first rising edge after rst_i deasserts.

Structure
REQ-024 The FSM state encoding, wait-counter width (4) and byte-lane constants SHALL live in shared package wb_ram_pkg.
REQ-025 The per-port FSM/counter SHALL be sub-module wb_ram_port (parameter WAIT), instantiated twice; the memory array stays in wb_dp_ram.

Verification
REQ-026 I_WAIT=0: preload word 0x100 = 32'hDEADBEEF, instruction read 0x100 -> ack 1 cycle after accept, dat 32'hDEADBEEF.
REQ-027 D_WAIT=3: write 0x200 = 32'h11223344 with sel=4'b0101, then read -> ack 4 cycles after each accept, read returns 32'h00220044 from a zeroed word.
REQ-028 Read address 32'h8000_0000 with BASE_ADDR 0 -> err pulses 1 cycle, ack stays 0, dat_o = 0, memory unchanged.
REQ-029 D_WAIT=3: drop cyc 2 cycles into a write to 0x300 -> no ack, word 0x300 unchanged.
REQ-030 Same-edge data write 32'hCAFEF00D and instruction read of word 0x40 (old 32'h12345678) -> instruction port returns 32'h12345678, a later read returns 32'hCAFEF00D.
REQ-031 Assert rst_i low during WAIT -> ack/err/dat_o go 0 without a clock edge, write dropped, next request after release served normally.

Source files
------------

// File: rtl/wb_ram_pkg.sv
// Shared definitions for the dual-port Wishbone RAM: port FSM states,
// wait-counter sizing and byte-lane geometry.
package wb_ram_pkg;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_WAIT,
    PORT_RESP
  } port_state_e;

  localparam int unsigned CNT_W = 4;
  typedef logic [CNT_W-1:0] wait_cnt_t;

  localparam int unsigned BYTE_LANES = 4;
  localparam int unsigned BYTE_W     = 8;

endpackage

// File: rtl/wb_ram_port.sv
// Per-port access sequencer: accepts a request, counts wait states and
// flags the edge on which the access commits and the response is raised.
module wb_ram_port
  import wb_ram_pkg::*;
#(
  parameter int unsigned WAIT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [29:0] addr_i,
  output logic        idle_o,
  output logic        accept_o,
  output logic        fire_o,
  output logic [29:0] addr_o
);

  port_state_e state_q, state_d;
  wait_cnt_t   cnt_q, cnt_d;
  logic [29:0] addr_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= PORT_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_o) addr_q <= addr_i;
    end
  end

  // fire_o is high in the cycle whose closing edge enters RESP; with no wait
  // states that is the accepting edge itself, so the live inputs are used.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_o = 1'b0;
    fire_o   = 1'b0;
    unique case (state_q)
      PORT_IDLE: begin
        if (cyc_i && stb_i) begin
          accept_o = 1'b1;
          if (WAIT == 0) begin
            state_d = PORT_RESP;
            fire_o  = 1'b1;
          end else begin
            state_d = PORT_WAIT;
            cnt_d   = wait_cnt_t'(WAIT);
          end
        end
      end
      PORT_WAIT: begin
        if (!cyc_i) begin
          state_d = PORT_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == wait_cnt_t'(1)) begin
          state_d = PORT_RESP;
          cnt_d   = '0;
          fire_o  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PORT_RESP: state_d = PORT_IDLE;
      default:   state_d = PORT_IDLE;
    endcase
  end

  assign idle_o = (state_q == PORT_IDLE);
  assign addr_o = idle_o ? addr_i : addr_q;

endmodule

// File: rtl/wb_dp_ram.sv
// Dual-port Wishbone RAM: read-only instruction port and byte-writable data
// port sharing one word array, each with its own configurable wait states.
module wb_dp_ram
  import wb_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 22,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned I_WAIT     = 0,
  parameter int unsigned D_WAIT     = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] iwbs_addr_i,
  input  logic        iwbs_cyc_i,
  input  logic        iwbs_stb_i,
  output logic [31:0] iwbs_dat_o,
  output logic        iwbs_ack_o,
  output logic        iwbs_err_o,
  input  logic [31:0] dwbs_addr_i,
  input  logic [31:0] dwbs_dat_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic        dwbs_cyc_i,
  input  logic        dwbs_stb_i,
  input  logic        dwbs_we_i,
  output logic [31:0] dwbs_dat_o,
  output logic        dwbs_ack_o,
  output logic        dwbs_err_o
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [31:0] mem [DEPTH];

  logic        i_idle, i_accept, i_fire, i_hit;
  logic        d_idle, d_accept, d_fire, d_hit;
  logic [29:0] i_word, d_word;
  logic        d_we_q, d_we;
  logic [3:0]  d_sel_q, d_sel;
  logic [31:0] d_wdat_q, d_wdat;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{iwbs_addr_i[1:0], dwbs_addr_i[1:0]};

  function automatic logic in_window(input logic [29:0] word);
    logic [31:0] byte_addr;
    byte_addr = {word, 2'b00};
    return byte_addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH];
  endfunction

  wb_ram_port #(.WAIT(I_WAIT)) u_iport (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cyc_i    (iwbs_cyc_i),
    .stb_i    (iwbs_stb_i),
    .addr_i   (iwbs_addr_i[31:2]),
    .idle_o   (i_idle),
    .accept_o (i_accept),
    .fire_o   (i_fire),
    .addr_o   (i_word)
  );

  wb_ram_port #(.WAIT(D_WAIT)) u_dport (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cyc_i    (dwbs_cyc_i),
    .stb_i    (dwbs_stb_i),
    .addr_i   (dwbs_addr_i[31:2]),
    .idle_o   (d_idle),
    .accept_o (d_accept),
    .fire_o   (d_fire),
    .addr_o   (d_word)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      d_we_q   <= 1'b0;
      d_sel_q  <= '0;
      d_wdat_q <= '0;
    end else if (d_accept) begin
      d_we_q   <= dwbs_we_i;
      d_sel_q  <= dwbs_sel_i;
      d_wdat_q <= dwbs_dat_i;
    end
  end

  // While idle the live bus is used so zero-wait accesses commit at acceptance.
  assign d_we   = d_idle ? dwbs_we_i  : d_we_q;
  assign d_sel  = d_idle ? dwbs_sel_i : d_sel_q;
  assign d_wdat = d_idle ? dwbs_dat_i : d_wdat_q;
  assign i_hit  = in_window(i_word);
  assign d_hit  = in_window(d_word);

  always_ff @(posedge clk_i) begin
    if (d_fire && d_hit && d_we) begin
      for (int unsigned b = 0; b < BYTE_LANES; b++) begin
        if (d_sel[b]) mem[d_word[IDX_W-1:0]][b*BYTE_W +: BYTE_W] <= d_wdat[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // Reads sample the array before any same-edge write lands.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      iwbs_ack_o <= 1'b0;
      iwbs_err_o <= 1'b0;
      iwbs_dat_o <= '0;
      dwbs_ack_o <= 1'b0;
      dwbs_err_o <= 1'b0;
      dwbs_dat_o <= '0;
    end else begin
      iwbs_ack_o <= i_fire && i_hit;
      iwbs_err_o <= i_fire && !i_hit;
      dwbs_ack_o <= d_fire && d_hit;
      dwbs_err_o <= d_fire && !d_hit;
      if (i_fire) iwbs_dat_o <= i_hit ? mem[i_word[IDX_W-1:0]] : '0;
      if (d_fire) dwbs_dat_o <= (d_hit && !d_we) ? mem[d_word[IDX_W-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_wb_dp_ram.sv
// Scoreboard bench for wb_dp_ram: drivers queue expected responses from a
// word-array reference model, per-port monitors check data, kind and latency.
module tb_wb_dp_ram;

  localparam int unsigned AW = 10;
  localparam int unsigned IW = 0;
  localparam int unsigned DW = 3;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int unsigned cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_cyc = 1'b0, i_stb = 1'b0;
  logic [31:0] i_dat;
  logic        i_ack, i_err;
  logic [31:0] d_addr = '0, d_wdat = '0;
  logic [3:0]  d_sel = '0;
  logic        d_cyc = 1'b0, d_stb = 1'b0, d_we = 1'b0;
  logic [31:0] d_rdat;
  logic        d_ack, d_err;

  rsp_t        iq[$];
  rsp_t        dq[$];
  logic [31:0] model [256];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc_cnt = 0;
  logic [31:0] i_last = '0, d_last = '0;

  wb_dp_ram #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (32'h0000_0000),
    .I_WAIT     (IW),
    .D_WAIT     (DW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .iwbs_addr_i (i_addr),
    .iwbs_cyc_i  (i_cyc),
    .iwbs_stb_i  (i_stb),
    .iwbs_dat_o  (i_dat),
    .iwbs_ack_o  (i_ack),
    .iwbs_err_o  (i_err),
    .dwbs_addr_i (d_addr),
    .dwbs_dat_i  (d_wdat),
    .dwbs_sel_i  (d_sel),
    .dwbs_cyc_i  (d_cyc),
    .dwbs_stb_i  (d_stb),
    .dwbs_we_i   (d_we),
    .dwbs_dat_o  (d_rdat),
    .dwbs_ack_o  (d_ack),
    .dwbs_err_o  (d_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return a[31:AW] == '0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {22'h0, 8'($urandom_range(0, 31)), 2'($urandom)};
    if ($urandom_range(0, 9) == 0) a[31:AW] = 22'($urandom_range(1, 32'h3F_FFFF));
    return a;
  endfunction

  // Called at a negedge; returns at the negedge where the response is visible.
  task automatic d_access(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                          input logic [31:0] wdat, input bit hold, input bit use_c,
                          input logic [31:0] c_exp);
    rsp_t e;
    bit   hit, got;
    hit = in_win(addr);
    d_addr = addr; d_we = we; d_sel = sel; d_wdat = wdat; d_cyc = 1'b1; d_stb = 1'b1;
    e.err = !hit;
    e.dat = (hit && !we) ? model[addr[9:2]] : 32'h0;
    if (use_c) e.dat = c_exp;
    e.cyc = cyc_cnt + 1 + DW;
    dq.push_back(e);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (d_ack || d_err) got = 1'b1;
      else begin
        d_addr = $urandom; d_we = 1'($urandom); d_sel = 4'($urandom);
        d_wdat = $urandom; d_stb = 1'($urandom);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL d_timeout actual=none required=response");
    end else if (hit && we) begin
      model[addr[9:2]] = merge(model[addr[9:2]], wdat, sel);
    end
    if (!hold) begin d_cyc = 1'b0; d_stb = 1'b0; end
  endtask

  task automatic i_access(input logic [31:0] addr, input bit hold, input bit use_c,
                          input logic [31:0] c_exp);
    rsp_t e;
    bit   got;
    i_addr = addr; i_cyc = 1'b1; i_stb = 1'b1;
    e.err = !in_win(addr);
    e.dat = in_win(addr) ? model[addr[9:2]] : 32'h0;
    if (use_c) e.dat = c_exp;
    e.cyc = cyc_cnt + 1 + IW;
    iq.push_back(e);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (i_ack || i_err) got = 1'b1;
      else begin i_addr = $urandom; i_stb = 1'($urandom); end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL i_timeout actual=none required=response");
    end
    if (!hold) begin i_cyc = 1'b0; i_stb = 1'b0; end
  endtask

  initial forever begin
    rsp_t e;
    @(negedge clk);
    if (!rst_n) i_last = '0;
    else if (i_ack || i_err) begin
      if (iq.size() == 0) chk("i_unexpected", {30'h0, i_ack, i_err}, 32'h0);
      else begin
        e = iq.pop_front();
        chk("i_kind", {30'h0, i_ack, i_err}, e.err ? 32'h1 : 32'h2);
        chk("i_dat", i_dat, e.dat);
        chk("i_latency", cyc_cnt, e.cyc);
        i_last = e.dat;
      end
    end else chk("i_hold", i_dat, i_last);
  end

  initial forever begin
    rsp_t e;
    @(negedge clk);
    if (!rst_n) d_last = '0;
    else if (d_ack || d_err) begin
      if (dq.size() == 0) chk("d_unexpected", {30'h0, d_ack, d_err}, 32'h0);
      else begin
        e = dq.pop_front();
        chk("d_kind", {30'h0, d_ack, d_err}, e.err ? 32'h1 : 32'h2);
        chk("d_dat", d_rdat, e.dat);
        chk("d_latency", cyc_cnt, e.cyc);
        d_last = e.dat;
      end
    end else chk("d_hold", d_rdat, d_last);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   kind, nkind;
    bit   hold;
    logic [31:0] a;

    for (int w = 0; w < 256; w++) model[w] = '0;
    repeat (3) @(negedge clk);
    chk("rst_i_ack", {31'h0, i_ack}, 32'h0);
    chk("rst_i_err", {31'h0, i_err}, 32'h0);
    chk("rst_i_dat", i_dat, 32'h0);
    chk("rst_d_ack", {31'h0, d_ack}, 32'h0);
    chk("rst_d_err", {31'h0, d_err}, 32'h0);
    chk("rst_d_dat", d_rdat, 32'h0);

    // Release and issue at once: first edge after release must accept.
    rst_n = 1'b1;
    for (int w = 0; w < 256; w++) begin
      d_access(32'(w * 4), 1'b1, 4'hF, 32'h0, w != 255, 1'b0, 32'h0);
      @(negedge clk);
    end

    d_access(32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0); @(negedge clk);
    i_access(32'h100, 1'b0, 1'b1, 32'hDEAD_BEEF);                    @(negedge clk);

    d_access(32'h200, 1'b1, 4'b0101, 32'h1122_3344, 1'b0, 1'b0, 32'h0); @(negedge clk);
    d_access(32'h200, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0022_0044);    @(negedge clk);

    i_access(32'h8000_0000, 1'b0, 1'b1, 32'h0);                              @(negedge clk);
    d_access(32'h8000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0);           @(negedge clk);
    d_access(32'h8000_0100, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);   @(negedge clk);
    i_access(32'h100, 1'b0, 1'b1, 32'hDEAD_BEEF);                            @(negedge clk);

    d_access(32'h300, 1'b1, 4'hF, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'h0); @(negedge clk);
    d_addr = 32'h300; d_we = 1'b1; d_sel = 4'hF; d_wdat = 32'h0; d_cyc = 1'b1; d_stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    d_cyc = 1'b0; d_stb = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("abort_no_ack", {30'h0, d_ack, d_err}, 32'h0);
    end
    d_access(32'h300, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'hA5A5_5A5A); @(negedge clk);

    d_access(32'h40, 1'b1, 4'hF, 32'h1234_5678, 1'b0, 1'b0, 32'h0); @(negedge clk);
    fork
      d_access(32'h40, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
      begin
        repeat (3) @(negedge clk);
        i_access(32'h40, 1'b0, 1'b1, 32'h1234_5678);
      end
    join
    @(negedge clk);
    i_access(32'h40, 1'b0, 1'b1, 32'hCAFE_F00D); @(negedge clk);

    d_access(32'h100, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0); @(negedge clk);
    d_addr = 32'h100; d_we = 1'b1; d_sel = 4'hF; d_wdat = 32'h0; d_cyc = 1'b1; d_stb = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_d_ack", {30'h0, d_ack, d_err}, 32'h0);
    chk("async_d_dat", d_rdat, 32'h0);
    chk("async_i_dat", i_dat, 32'h0);
    d_cyc = 1'b0; d_stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d_access(32'h100, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF); @(negedge clk);

    nkind = $urandom_range(0, 2);
    for (int t = 0; t < 300; t++) begin
      kind  = nkind;
      nkind = $urandom_range(0, 2);
      hold  = ((kind == 0) == (nkind == 0)) && ($urandom_range(0, 1) == 1);
      a     = rand_addr();
      case (kind)
        0:       i_access(a, hold, 1'b0, 32'h0);
        1:       d_access(a, 1'b0, 4'hF, 32'h0, hold, 1'b0, 32'h0);
        default: d_access(a, 1'b1, 4'($urandom), $urandom, hold, 1'b0, 32'h0);
      endcase
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
    end
    i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;

    repeat (10) @(negedge clk);
    chk("iq_drained", iq.size(), 32'h0);
    chk("dq_drained", dq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
